// File: rtl/tl_sensor_cond.sv
// Detector conditioning for the left-turn traffic light controller:
// per-input synchroniser + debounce, plus latched left-turn requests.

module tl_sensor_chan #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Counter only runs while the synchronised input disagrees with the
  // accepted level, so any reversal restarts the qualification window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module tl_sensor_cond #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_a,
  input  logic       raw_al,
  input  logic       raw_b,
  input  logic       raw_bl,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl
);

  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_ARROW  = 2'b10,
    LIGHT_RED    = 2'b11
  } light_t;

  logic f_al;
  logic f_bl;
  logic arrow_a;
  logic arrow_b;

  tl_sensor_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan_a (
    .clk(clk), .reset_n(reset_n), .raw(raw_a), .level(Ta)
  );

  tl_sensor_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan_al (
    .clk(clk), .reset_n(reset_n), .raw(raw_al), .level(f_al)
  );

  tl_sensor_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan_b (
    .clk(clk), .reset_n(reset_n), .raw(raw_b), .level(Tb)
  );

  tl_sensor_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan_bl (
    .clk(clk), .reset_n(reset_n), .raw(raw_bl), .level(f_bl)
  );

  always_comb begin
    arrow_a = (light_t'(La) == LIGHT_ARROW);
    arrow_b = (light_t'(Lb) == LIGHT_ARROW);
  end

  // Serving the arrow clears the request and overrides a concurrent set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Tal <= 1'b0;
      Tbl <= 1'b0;
    end else begin
      Tal <= (Tal | f_al) & ~arrow_a;
      Tbl <= (Tbl | f_bl) & ~arrow_b;
    end
  end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Scoreboard bench for tl_sensor_cond: a history-window model predicts
// outputs per edge; directed scenarios also check absolute latencies.

module tb_tl_sensor_cond;

  localparam int DEB = 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       raw_a   = 1'b0;
  logic       raw_al  = 1'b0;
  logic       raw_b   = 1'b0;
  logic       raw_bl  = 1'b0;
  logic [1:0] La      = 2'b11;
  logic [1:0] Lb      = 2'b11;
  logic       Ta, Tal, Tb, Tbl;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "reset";

  logic [3:0] sb_q[$];
  bit         m_sh[4][DEB+1];
  bit         m_f[4];
  bit         m_tal, m_tbl;

  tl_sensor_cond #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .raw_a(raw_a), .raw_al(raw_al), .raw_b(raw_b), .raw_bl(raw_bl),
    .La(La), .Lb(Lb),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %0h expected %0h", tag, phase, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_f[c] = 1'b0;
      for (int j = 0; j <= DEB; j++) m_sh[c][j] = 1'b0;
    end
    m_tal = 1'b0;
    m_tbl = 1'b0;
  endtask

  // m_sh[c][j] is the raw value captured j edges before the coming edge
  // (j=0: the most recent capture). A level is accepted once the last DEB
  // values seen at the second sync stage all agree and differ from it.
  task automatic model_push();
    bit raw[4];
    bit nf[4];
    bit v, all_eq;
    raw[0] = raw_a; raw[1] = raw_al; raw[2] = raw_b; raw[3] = raw_bl;
    for (int c = 0; c < 4; c++) begin
      nf[c]  = m_f[c];
      v      = m_sh[c][1];
      all_eq = 1'b1;
      for (int j = 2; j <= DEB; j++) if (m_sh[c][j] != v) all_eq = 1'b0;
      if (all_eq && v != m_f[c]) nf[c] = v;
    end
    m_tal = (m_tal | m_f[1]) & (La != 2'b10);
    m_tbl = (m_tbl | m_f[3]) & (Lb != 2'b10);
    for (int c = 0; c < 4; c++) begin
      for (int j = DEB; j > 0; j--) m_sh[c][j] = m_sh[c][j-1];
      m_sh[c][0] = raw[c];
      m_f[c] = nf[c];
    end
    sb_q.push_back({nf[0], m_tal, nf[2], m_tbl});
  endtask

  task automatic tick();
    logic [3:0] exp;
    model_push();
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("outs{Ta,Tal,Tb,Tbl}", {28'd0, Ta, Tal, Tb, Tbl}, {28'd0, exp});
  endtask

  initial begin
    int lat, lat2, lat3, lat4, cnt;
    logic seen;

    model_reset();
    #2;
    check("rst_outs", {28'd0, Ta, Tal, Tb, Tbl}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    phase = "rise_fall";
    raw_a = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (Ta && lat == 0) lat = i;
    end
    check("a_rise_edge", lat, 6);
    raw_a = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!Ta && lat == 0) lat = i;
    end
    check("a_fall_edge", lat, 6);

    phase = "glitch";
    raw_b = 1'b1;
    seen  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      seen |= Tb;
    end
    raw_b = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      seen |= Tb;
    end
    check("b_short_pulse", seen, 0);
    raw_b = 1'b1;
    lat = 0;
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) raw_b = 1'b0;
      tick();
      if (Tb) begin
        cnt++;
        if (lat == 0) lat = i;
      end
    end
    check("b_pulse_first", lat, 6);
    check("b_pulse_width", cnt, 4);

    phase = "left_serve";
    raw_al = 1'b1;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 7) raw_al = 1'b0;
      tick();
      if (Tal && lat == 0) lat = i;
    end
    check("al_set_edge", lat, 7);
    check("al_held", Tal, 1);
    La = 2'b10;
    tick();
    check("al_served", Tal, 0);
    La = 2'b11;
    for (int i = 1; i <= 3; i++) tick();
    check("al_stays_clear", Tal, 0);

    phase = "clear_prio";
    raw_bl = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    check("bl_set", Tbl, 1);
    Lb = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("bl_forced_clear", Tbl, 0);
    end
    Lb = 2'b00;
    tick();
    check("bl_rerequest", Tbl, 1);
    raw_bl = 1'b0;
    Lb = 2'b01;
    for (int i = 1; i <= 8; i++) tick();
    check("bl_yellow_no_clear", Tbl, 1);

    phase = "async_reset";
    Lb = 2'b11;
    raw_al = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    raw_al = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    check("al_latched_pre_rst", Tal, 1);
    raw_a = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", {28'd0, Ta, Tal, Tb, Tbl}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) check("first_edge_after_rst", {28'd0, Ta, Tal, Tb, Tbl}, 32'd0);
      if (Ta && lat == 0) lat = i;
    end
    check("a_rise_after_rst", lat, 6);

    phase = "independence";
    raw_a = 1'b0;
    La = 2'b10;
    Lb = 2'b10;
    for (int i = 1; i <= 8; i++) tick();
    La = 2'b11;
    Lb = 2'b11;
    tick();
    raw_a = 1'b1; raw_al = 1'b1; raw_b = 1'b1; raw_bl = 1'b1;
    lat = 0; lat2 = 0; lat3 = 0; lat4 = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (Ta  && lat  == 0) lat  = i;
      if (Tb  && lat2 == 0) lat2 = i;
      if (Tal && lat3 == 0) lat3 = i;
      if (Tbl && lat4 == 0) lat4 = i;
    end
    check("all_Ta_edge", lat, 6);
    check("all_Tb_edge", lat2, 6);
    check("all_Tal_edge", lat3, 7);
    check("all_Tbl_edge", lat4, 7);
    raw_a = 1'b0; raw_al = 1'b0; raw_b = 1'b0; raw_bl = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    check("latches_hold_after_drop", {30'd0, Tal, Tbl}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
